// File: rtl/pcie_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pcie_pkg : shared FSM states, completion status codes and header layout
// Rev 1.0
// ---------------------------------------------------------------------------
package pcie_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_FETCH = 3'd2,
    ST_CAPT  = 3'd3,
    ST_SEND  = 3'd4
  } cpl_state_e;

  localparam logic [2:0] CPL_SC = 3'b000;
  localparam logic [2:0] CPL_UR = 3'b001;

  localparam int HDR_TAG_LSB    = 24;
  localparam int HDR_CPLID_LSB  = 16;
  localparam int HDR_STATUS_LSB = 13;

  localparam int REQ_W = 44;

  typedef struct packed {
    logic [7:0]  tag;
    logic [31:0] addr;
    logic [3:0]  len;
  } req_t;

  function automatic logic [31:0] cpl_hdr(input logic [7:0] tag, input logic [7:0] cpl_id,
                                          input logic [2:0] status, input logic [9:0] len_dw);
    return (32'(tag) << HDR_TAG_LSB) | (32'(cpl_id) << HDR_CPLID_LSB) |
           (32'(status) << HDR_STATUS_LSB) | 32'(len_dw);
  endfunction

  // 33-bit end address so a request near 2^32 cannot wrap into range
  function automatic logic [2:0] req_status(input logic [31:0] addr, input logic [3:0] len,
                                            input logic [32:0] limit);
    logic [32:0] end_addr;
    end_addr = {1'b0, addr} + {29'd0, len};
    return ((len == 4'd0) || (end_addr > limit)) ? CPL_UR : CPL_SC;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pcie_req_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pcie_req_fifo : request queue with registered occupancy and full/empty flags
// Rev 1.0
// ---------------------------------------------------------------------------
module pcie_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 44
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en, rd_en;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];

  // a write into a full queue is legal when the head leaves on the same edge
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/pcie_completer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pcie_completer : queues memory read requests and returns header + data beats
// Rev 1.0
// ---------------------------------------------------------------------------
module pcie_completer
  import pcie_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] CPL_ID     = 8'h01,
  parameter int         MEM_DW     = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_tag,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_len,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rd_data,
  output logic        cpl_valid,
  input  logic        cpl_ready,
  output logic        cpl_sop,
  output logic        cpl_eop,
  output logic [31:0] cpl_header,
  output logic [31:0] cpl_data,
  output logic        busy
);
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [REQ_W-1:0] fifo_rd_data;
  req_t             head;
  logic [2:0]       head_status;

  cpl_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] hdr_q, hdr_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  remain_q, remain_d;
  logic        ur_q, ur_d;
  logic        avail_q, avail_d;

  assign req_ready   = !fifo_full;
  assign fifo_push   = req_valid && req_ready;
  assign head        = fifo_rd_data;
  assign head_status = req_status(head.addr, head.len, 33'(MEM_DW));
  assign busy        = !fifo_empty || (state_q != ST_IDLE);
  assign cpl_header  = hdr_q;
  assign cpl_data    = data_q;
  assign avail_d     = !fifo_empty;

  pcie_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REQ_W)
  ) u_req_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .wr_data ({req_tag, req_addr, req_len}),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    hdr_d     = hdr_q;
    data_d    = data_q;
    remain_d  = remain_q;
    ur_d      = ur_q;
    fifo_pop  = 1'b0;
    cpl_valid = 1'b0;
    cpl_sop   = 1'b0;
    cpl_eop   = 1'b0;
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    case (state_q)
      ST_IDLE: begin
        // avail_q delays the pop by one cycle after the queue turns non-empty
        if (avail_q && !fifo_empty) begin
          fifo_pop = 1'b1;
          ur_d     = (head_status != CPL_SC);
          hdr_d    = cpl_hdr(head.tag, CPL_ID, head_status,
                             (head_status == CPL_SC) ? {6'd0, head.len} : 10'd0);
          addr_d   = head.addr;
          remain_d = head.len;
          state_d  = ST_HDR;
        end
      end
      ST_HDR: begin
        cpl_valid = 1'b1;
        cpl_sop   = 1'b1;
        cpl_eop   = ur_q;
        if (cpl_ready) state_d = ur_q ? ST_IDLE : ST_FETCH;
      end
      ST_FETCH: begin
        mem_rd_en = 1'b1;
        mem_addr  = addr_q;
        state_d   = ST_CAPT;
      end
      ST_CAPT: begin
        data_d   = mem_rd_data;
        addr_d   = addr_q + 32'd1;
        remain_d = remain_q - 4'd1;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        cpl_valid = 1'b1;
        cpl_eop   = (remain_q == 4'd0);
        if (cpl_ready) state_d = (remain_q == 4'd0) ? ST_IDLE : ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      hdr_q    <= '0;
      data_q   <= '0;
      remain_q <= '0;
      ur_q     <= 1'b0;
      avail_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      hdr_q    <= hdr_d;
      data_q   <= data_d;
      remain_q <= remain_d;
      ur_q     <= ur_d;
      avail_q  <= avail_d;
    end
  end

endmodule
`default_nettype wire
